// File: rtl/sht40_convert.sv
// Converts raw SHT40 temperature/humidity words to centi-units with one shared shift-add multiplier.
// Define SHT40_CONVERT_AVG_EN to output a running mean of the last 4 results per channel.
module sht40_convert #(
  parameter int T_SCALE   = 17500,
  parameter int T_OFFSET  = 4500,
  parameter int RH_SCALE  = 12500,
  parameter int RH_OFFSET = 600,
  parameter int RH_MAX    = 10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] Temperature_Output,
  input  logic [15:0] Humidity_Output,
  input  logic        Temp_Ready_Out,
  input  logic        RH_Ready_Out,
  output logic [15:0] Temp_Centi,
  output logic [15:0] RH_Centi,
  output logic        Temp_Valid,
  output logic        RH_Valid,
  output logic        Conv_Busy
);

`ifdef SHT40_CONVERT_AVG_EN
  typedef enum logic [2:0] {IDLE, MUL, ADJ, AVG, OUT} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, ADJ, OUT} state_t;
`endif

  state_t      state;
  logic        t_hist, rh_hist, t_pend, rh_pend;
  logic [15:0] t_hold, rh_hold;
  logic        ch;            // 0 = temperature, 1 = humidity
  logic [15:0] op;
  logic [31:0] mcand, acc;
  logic [3:0]  cnt;
  logic [15:0] res;

  logic t_rise, rh_rise, t_start, rh_start;
  assign t_rise   = Temp_Ready_Out & ~t_hist;
  assign rh_rise  = RH_Ready_Out & ~rh_hist;
  assign t_start  = (state == IDLE) & t_pend;
  assign rh_start = (state == IDLE) & ~t_pend & rh_pend;

  logic signed [17:0] diff;
  logic [15:0]        adj_val;
  always_comb begin
    diff    = $signed({2'b00, acc[31:16]}) - (ch ? 18'(RH_OFFSET) : 18'(T_OFFSET));
    adj_val = diff[15:0];
    if (ch) begin
      if (diff < 18'sd0)                adj_val = 16'd0;
      else if (diff > 18'(RH_MAX))      adj_val = 16'(RH_MAX);
    end
  end

`ifdef SHT40_CONVERT_AVG_EN
  // Three previous results per channel; with the fresh result they form the 4-deep window.
  logic [2:0][15:0]   t_hq, rh_hq;
  logic [2:0]         t_fill, rh_fill;
  logic signed [17:0] t_sum;
  logic [17:0]        rh_sum;
  always_comb begin
    t_sum  = $signed({{2{res[15]}}, res}) + $signed({{2{t_hq[0][15]}}, t_hq[0]})
           + $signed({{2{t_hq[1][15]}}, t_hq[1]}) + $signed({{2{t_hq[2][15]}}, t_hq[2]});
    rh_sum = {2'b00, res} + {2'b00, rh_hq[0]} + {2'b00, rh_hq[1]} + {2'b00, rh_hq[2]};
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      t_hist     <= 1'b1;
      rh_hist    <= 1'b1;
      t_pend     <= 1'b0;
      rh_pend    <= 1'b0;
      t_hold     <= '0;
      rh_hold    <= '0;
      ch         <= 1'b0;
      op         <= '0;
      mcand      <= '0;
      acc        <= '0;
      cnt        <= '0;
      res        <= '0;
      Temp_Centi <= '0;
      RH_Centi   <= '0;
      Temp_Valid <= 1'b0;
      RH_Valid   <= 1'b0;
      Conv_Busy  <= 1'b0;
`ifdef SHT40_CONVERT_AVG_EN
      t_hq       <= '0;
      rh_hq      <= '0;
      t_fill     <= '0;
      rh_fill    <= '0;
`endif
    end else begin
      t_hist     <= Temp_Ready_Out;
      rh_hist    <= RH_Ready_Out;
      Temp_Valid <= 1'b0;
      RH_Valid   <= 1'b0;
      if (t_rise)  t_hold  <= Temperature_Output;
      if (rh_rise) rh_hold <= Humidity_Output;
      // A fresh edge on the starting channel's input re-arms it with the newer word.
      t_pend  <= t_rise  | (t_pend  & ~t_start);
      rh_pend <= rh_rise | (rh_pend & ~rh_start);
      case (state)
        IDLE: begin
          if (t_start || rh_start) begin
            ch        <= rh_start;
            op        <= t_start ? t_hold : rh_hold;
            mcand     <= t_start ? 32'(T_SCALE) : 32'(RH_SCALE);
            acc       <= '0;
            cnt       <= '0;
            Conv_Busy <= 1'b1;
            state     <= MUL;
          end
        end
        MUL: begin
          if (op[0]) acc <= acc + mcand;
          op    <= op >> 1;
          mcand <= mcand << 1;
          cnt   <= cnt + 4'd1;
          if (cnt == 4'd15) state <= ADJ;
        end
        ADJ: begin
          res <= adj_val;
`ifdef SHT40_CONVERT_AVG_EN
          state <= AVG;
`else
          state <= OUT;
`endif
        end
`ifdef SHT40_CONVERT_AVG_EN
        AVG: begin
          if (!ch) begin
            t_hq   <= {t_hq[1:0], res};
            t_fill <= (t_fill == 3'd4) ? 3'd4 : t_fill + 3'd1;
            res    <= t_sum[17:2];
          end else begin
            rh_hq   <= {rh_hq[1:0], res};
            rh_fill <= (rh_fill == 3'd4) ? 3'd4 : rh_fill + 3'd1;
            res     <= rh_sum[17:2];
          end
          state <= OUT;
        end
        OUT: begin
          if (!ch && t_fill == 3'd4) begin
            Temp_Centi <= res;
            Temp_Valid <= 1'b1;
          end
          if (ch && rh_fill == 3'd4) begin
            RH_Centi <= res;
            RH_Valid <= 1'b1;
          end
          Conv_Busy <= 1'b0;
          state     <= IDLE;
        end
`else
        OUT: begin
          if (!ch) begin
            Temp_Centi <= res;
            Temp_Valid <= 1'b1;
          end else begin
            RH_Centi <= res;
            RH_Valid <= 1'b1;
          end
          Conv_Busy <= 1'b0;
          state     <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sht40_convert.sv
// Bench for sht40_convert: table vectors, hand sequences and random samples against an arithmetic model.
module tb_sht40_convert;
`ifdef SHT40_CONVERT_AVG_EN
  localparam int LAT = 20;
`else
  localparam int LAT = 19;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] Temperature_Output = '0, Humidity_Output = '0;
  logic        Temp_Ready_Out = 1'b0, RH_Ready_Out = 1'b0;
  logic [15:0] Temp_Centi, RH_Centi;
  logic        Temp_Valid, RH_Valid, Conv_Busy;

  always #5 clk = ~clk;

  sht40_convert dut (
    .clk(clk), .rst_n(rst_n),
    .Temperature_Output(Temperature_Output), .Humidity_Output(Humidity_Output),
    .Temp_Ready_Out(Temp_Ready_Out), .RH_Ready_Out(RH_Ready_Out),
    .Temp_Centi(Temp_Centi), .RH_Centi(RH_Centi),
    .Temp_Valid(Temp_Valid), .RH_Valid(RH_Valid), .Conv_Busy(Conv_Busy)
  );

  typedef struct { int cyc; bit ch; int val; } ev_t;
  ev_t evq[$];
  int  cyc = 0;
  int  total = 0, bad = 0;
  int  tq[$], rq[$];

  // Log every valid strobe with its edge number.
  always @(posedge clk) begin
    ev_t e;
    cyc = cyc + 1;
    #1;
    if (Temp_Valid) begin e.cyc = cyc; e.ch = 1'b0; e.val = int'($signed(Temp_Centi)); evq.push_back(e); end
    if (RH_Valid)   begin e.cyc = cyc; e.ch = 1'b1; e.val = int'(RH_Centi);            evq.push_back(e); end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Reference: floor(raw*scale/2^16) - offset, humidity clamped, optional 4-sample mean.
  task automatic model(input bit ch, input int raw, output bit has, output int val);
    int v, s;
    if (!ch) v = (raw * 17500) / 65536 - 4500;
    else begin
      v = (raw * 12500) / 65536 - 600;
      if (v < 0) v = 0;
      if (v > 10000) v = 10000;
    end
`ifdef SHT40_CONVERT_AVG_EN
    if (!ch) begin
      tq.push_back(v); if (tq.size() > 4) void'(tq.pop_front());
      s = 0; foreach (tq[i]) s += tq[i];
      has = (tq.size() == 4);
    end else begin
      rq.push_back(v); if (rq.size() > 4) void'(rq.pop_front());
      s = 0; foreach (rq[i]) s += rq[i];
      has = (rq.size() == 4);
    end
    val = s >>> 2;
`else
    s = 0; has = 1'b1; val = v;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    tq.delete(); rq.delete();
    step();
  endtask

  task automatic conv1(input string nm, input bit ch, input logic [15:0] raw, input bit has, input int val);
    int n;
    evq.delete();
    n = cyc + 1;
    if (ch) begin Humidity_Output = raw; RH_Ready_Out = 1'b1; end
    else begin Temperature_Output = raw; Temp_Ready_Out = 1'b1; end
    step();
    Temp_Ready_Out = 1'b0; RH_Ready_Out = 1'b0;
    repeat (4) step();
    chk({nm, " busy"}, int'(Conv_Busy), 1);
    repeat (LAT + 2) step();
    chk({nm, " nvalid"}, evq.size(), has ? 1 : 0);
    if (evq.size() > 0) begin
      chk({nm, " latency"}, evq[0].cyc - n, LAT);
      chk({nm, " channel"}, int'(evq[0].ch), int'(ch));
      chk({nm, " value"}, evq[0].val, val);
    end
    chk({nm, " idle"}, int'(Conv_Busy), 0);
  endtask

  typedef struct { bit ch; logic [15:0] raw; int exp; } vec_t;
  vec_t tbl[9];

  initial begin
    bit has; int val, n;
    tbl[0] = '{1'b0, 16'h6666, 2499};
    tbl[1] = '{1'b0, 16'h0000, -4500};
    tbl[2] = '{1'b0, 16'hFFFF, 12999};
    tbl[3] = '{1'b0, 16'h8000, 4250};
    tbl[4] = '{1'b1, 16'h8000, 5650};
    tbl[5] = '{1'b1, 16'h0000, 0};
    tbl[6] = '{1'b1, 16'hFFFF, 10000};
    tbl[7] = '{1'b1, 16'h0C80, 10};
    tbl[8] = '{1'b1, 16'hD8CC, 9985};

    repeat (3) step();
    chk("rst Temp_Centi", int'(Temp_Centi), 0);
    chk("rst RH_Centi", int'(RH_Centi), 0);
    chk("rst Temp_Valid", int'(Temp_Valid), 0);
    chk("rst RH_Valid", int'(RH_Valid), 0);
    chk("rst Conv_Busy", int'(Conv_Busy), 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
`ifdef SHT40_CONVERT_AVG_EN
      model(tbl[i].ch, int'(tbl[i].raw), has, val);
`else
      has = 1'b1; val = tbl[i].exp;
`endif
      conv1($sformatf("vec%0d", i), tbl[i].ch, tbl[i].raw, has, val);
    end

`ifndef SHT40_CONVERT_AVG_EN
    // Both channels at once, then two temperature edges while humidity converts.
    evq.delete();
    n = cyc + 1;
    Temperature_Output = 16'h6666; Humidity_Output = 16'h8000;
    Temp_Ready_Out = 1'b1; RH_Ready_Out = 1'b1;
    step();
    Temp_Ready_Out = 1'b0; RH_Ready_Out = 1'b0;
    repeat (24) step();
    Temperature_Output = 16'h0000; Temp_Ready_Out = 1'b1;
    step();
    Temp_Ready_Out = 1'b0;
    repeat (2) step();
    Temperature_Output = 16'hFFFF; Temp_Ready_Out = 1'b1;
    step();
    Temp_Ready_Out = 1'b0;
    repeat (45) step();
    chk("b2b count", evq.size(), 3);
    if (evq.size() == 3) begin
      chk("b2b t cyc", evq[0].cyc - n, 19);
      chk("b2b t ch", int'(evq[0].ch), 0);
      chk("b2b t val", evq[0].val, 2499);
      chk("b2b rh cyc", evq[1].cyc - n, 38);
      chk("b2b rh ch", int'(evq[1].ch), 1);
      chk("b2b rh val", evq[1].val, 5650);
      chk("b2b t2 cyc", evq[2].cyc - n, 57);
      chk("b2b t2 ch", int'(evq[2].ch), 0);
      chk("b2b t2 val", evq[2].val, 12999);
    end
`endif

    for (int i = 0; i < 16; i++) begin
      bit c; logic [15:0] r;
      c = 1'($urandom_range(0, 1));
      r = 16'($urandom);
      model(c, int'(r), has, val);
      conv1($sformatf("rnd%0d", i), c, r, has, val);
    end

    // Ready held high through reset release must not start a conversion.
    Temp_Ready_Out = 1'b1;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    tq.delete(); rq.delete();
    evq.delete();
    repeat (30) step();
    chk("held ready valids", evq.size(), 0);
    chk("held ready busy", int'(Conv_Busy), 0);
    Temp_Ready_Out = 1'b0;
    step();

    // Establish a nonzero output, then abort a conversion mid-multiply.
    evq.delete();
    Humidity_Output = 16'h8000; RH_Ready_Out = 1'b1;
    rst_n = 1'b0; step(); rst_n = 1'b1; RH_Ready_Out = 1'b0; step();
`ifndef SHT40_CONVERT_AVG_EN
    conv1("pre abort", 1'b1, 16'h8000, 1'b1, 5650);
`endif
    evq.delete();
    Temperature_Output = 16'h6666; Temp_Ready_Out = 1'b1;
    step();
    Temp_Ready_Out = 1'b0;
    repeat (9) step();
    chk("abort busy before", int'(Conv_Busy), 1);
    rst_n = 1'b0;
    step();
    chk("abort Temp_Centi", int'(Temp_Centi), 0);
    chk("abort RH_Centi", int'(RH_Centi), 0);
    chk("abort busy", int'(Conv_Busy), 0);
    rst_n = 1'b1;
    tq.delete(); rq.delete();
    repeat (30) step();
    chk("abort valids", evq.size(), 0);

`ifdef SHT40_CONVERT_AVG_EN
    do_reset();
    model(1'b0, 0, has, val);      conv1("avg s1", 1'b0, 16'h0000, has, val);
    model(1'b0, 0, has, val);      conv1("avg s2", 1'b0, 16'h0000, has, val);
    model(1'b0, 65535, has, val);  conv1("avg s3", 1'b0, 16'hFFFF, has, val);
    model(1'b0, 65535, has, val);  conv1("avg s4", 1'b0, 16'hFFFF, has, val);
    chk("avg4 Temp_Centi", int'($signed(Temp_Centi)), 4249);
`else
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
